// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Multi-read, dual-write register file with optional zero
//                register, write-to-read bypass, collision flag and clear sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clear,
    input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
    output logic [NUM_RD*DATA_W-1:0] o_rdata,
    input  logic                     i_we0,
    input  logic [ADDR_W-1:0]        i_waddr0,
    input  logic [DATA_W-1:0]        i_wdata0,
    input  logic                     i_we1,
    input  logic [ADDR_W-1:0]        i_waddr1,
    input  logic [DATA_W-1:0]        i_wdata1,
    output logic                     o_busy,
    output logic                     o_collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0]        c_IDLE     = 1'b0;
    localparam logic [0:0]        c_CLEAR    = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_IDX = '1;
    localparam bit                c_ZERO_EN  = (ZERO_REG != 0);
    localparam bit                c_BYPASS   = (BYPASS != 0);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_collision;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic w_busy;
    logic w_wr_ok;
    logic w_wr0;
    logic w_wr1;
    logic w_coll;

    assign w_busy  = (r_state == c_CLEAR);
    // A clear request in IDLE takes priority over any write in the same cycle.
    assign w_wr_ok = !w_busy && !i_clear;
    assign w_wr0   = i_we0 && w_wr_ok && !(c_ZERO_EN && (i_waddr0 == '0));
    assign w_wr1   = i_we1 && w_wr_ok && !(c_ZERO_EN && (i_waddr1 == '0));
    assign w_coll  = w_wr0 && w_wr1 && (i_waddr0 == i_waddr1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= c_CLEAR;
            r_cnt       <= '0;
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_coll;
            case (r_state)
                c_CLEAR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_IDX) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    if (i_clear) begin
                        r_state <= c_CLEAR;
                        r_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (w_busy) begin
                r_mem[r_cnt] <= '0;
            end else begin
                if (w_wr0) begin
                    r_mem[i_waddr0] <= i_wdata0;
                end
                if (w_wr1) begin
                    r_mem[i_waddr1] <= i_wdata1;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            logic [DATA_W-1:0] w_rd;

            assign w_ra = i_raddr[k*ADDR_W +: ADDR_W];

            always_comb begin
                w_rd = r_mem[w_ra];
                if (c_BYPASS && w_wr1 && (i_waddr1 == w_ra)) begin
                    w_rd = i_wdata1;
                end else if (c_BYPASS && w_wr0 && (i_waddr0 == w_ra)) begin
                    w_rd = i_wdata0;
                end
                if (w_busy || (c_ZERO_EN && (w_ra == '0))) begin
                    w_rd = '0;
                end
            end

            assign o_rdata[k*DATA_W +: DATA_W] = w_rd;
        end
    endgenerate

    assign o_busy      = w_busy;
    assign o_collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_clear;
    logic [9:0]  i_raddr;
    logic [63:0] o_rdata;
    logic        i_we0;
    logic [4:0]  i_waddr0;
    logic [31:0] i_wdata0;
    logic        i_we1;
    logic [4:0]  i_waddr1;
    logic [31:0] i_wdata1;
    logic        o_busy;
    logic        o_collision;

    int n_checks = 0;
    int n_errors = 0;

    reg_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
        .i_raddr(i_raddr), .o_rdata(o_rdata),
        .i_we0(i_we0), .i_waddr0(i_waddr0), .i_wdata0(i_wdata0),
        .i_we1(i_we1), .i_waddr1(i_waddr1), .i_wdata1(i_wdata1),
        .o_busy(o_busy), .o_collision(o_collision)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Model: contents, cycles of sweep remaining, collision flag.
    logic [31:0] m_mem [32];
    int          m_rem   = 0;
    logic        m_coll  = 1'b0;
    logic        m_valid = 1'b0;

    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            m_valid = 1'b1;
            m_rem   = 32;
            m_coll  = 1'b0;
            for (int i = 0; i < 32; i++) m_mem[i] = '0;
        end else if (m_valid) begin
            if (m_rem > 0) begin
                m_rem  = m_rem - 1;
                m_coll = 1'b0;
            end else if (i_clear) begin
                m_rem  = 32;
                m_coll = 1'b0;
                for (int i = 0; i < 32; i++) m_mem[i] = '0;
            end else begin
                m_coll = i_we0 && i_we1 && (i_waddr0 == i_waddr1) && (i_waddr0 != 0);
                if (i_we0 && i_waddr0 != 0) m_mem[i_waddr0] = i_wdata0;
                if (i_we1 && i_waddr1 != 0) m_mem[i_waddr1] = i_wdata1;
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (m_rem != 0 || a == 0) return 32'h0;
        if (i_we1 && i_waddr1 == a) return i_wdata1;
        if (i_we0 && i_waddr0 == a) return i_wdata0;
        return m_mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (m_valid) begin
            check("busy", 32'(o_busy), 32'(m_rem != 0));
            check("collision", 32'(o_collision), 32'(m_coll));
            // A clear request in IDLE drops the write; forwarding that cycle is left unchecked.
            if (!(m_rem == 0 && i_clear)) begin
                for (int k = 0; k < 2; k++)
                    check("rdata", o_rdata[k*32 +: 32], exp_read(i_raddr[k*5 +: 5]));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (o_busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 32; i++) begin
            i_raddr = {5'(31 - i), 5'(i)};
            #1;
            check(name, o_rdata[31:0], 32'h0);
            check(name, o_rdata[63:32], 32'h0);
        end
    endtask

    int n;

    initial begin
        i_rst_n = 1'b0; i_clear = 1'b0; i_raddr = '0;
        i_we0 = 1'b0; i_waddr0 = '0; i_wdata0 = '0;
        i_we1 = 1'b0; i_waddr1 = '0; i_wdata1 = '0;
        tick();
        i_rst_n = 1'b1;

        // Reset sweep
        count_busy(n);
        check("reset_busy_len", n, 32);
        check("reset_coll", 32'(o_collision), 32'h0);
        check_all_zero("reset_zero");

        // Single write
        i_we0 = 1'b1; i_waddr0 = 5; i_wdata0 = 32'h4;
        tick();
        i_we0 = 1'b0; i_raddr = {5'd0, 5'd5};
        #1 check("write_r5", o_rdata[31:0], 32'h4);

        // Bypass
        i_we1 = 1'b1; i_waddr1 = 7; i_wdata1 = 32'hDEAD_BEEF; i_raddr = {5'd7, 5'd7};
        #1 check("bypass_r7", o_rdata[31:0], 32'hDEAD_BEEF);
        check("bypass_r7_p1", o_rdata[63:32], 32'hDEAD_BEEF);
        tick();
        i_we1 = 1'b0;
        #1 check("array_r7", o_rdata[31:0], 32'hDEAD_BEEF);

        // Collision
        i_we0 = 1'b1; i_waddr0 = 3; i_wdata0 = 32'h11;
        i_we1 = 1'b1; i_waddr1 = 3; i_wdata1 = 32'h22;
        tick();
        i_we0 = 1'b0; i_we1 = 1'b0; i_raddr = {5'd0, 5'd3};
        #1 check("coll_r3", o_rdata[31:0], 32'h22);
        check("coll_flag", 32'(o_collision), 32'h1);
        tick();
        check("coll_clr", 32'(o_collision), 32'h0);

        // Zero register writes
        i_we0 = 1'b1; i_waddr0 = 0; i_wdata0 = 32'h55;
        i_we1 = 1'b1; i_waddr1 = 0; i_wdata1 = 32'h66; i_raddr = {5'd0, 5'd0};
        #1 check("zero_bypass", o_rdata[31:0], 32'h0);
        tick();
        i_we0 = 1'b0; i_we1 = 1'b0;
        #1 check("zero_r0", o_rdata[31:0], 32'h0);
        check("zero_coll", 32'(o_collision), 32'h0);

        // Fill, then clear with a simultaneous write; writes while busy are dropped
        for (int i = 1; i < 32; i++) begin
            i_we0 = 1'b1; i_waddr0 = 5'(i); i_wdata0 = 32'(i);
            tick();
        end
        i_we0 = 1'b0; i_raddr = {5'd31, 5'd17};
        #1 check("fill_r17", o_rdata[31:0], 32'd17);
        check("fill_r31", o_rdata[63:32], 32'd31);
        i_clear = 1'b1; i_we0 = 1'b1; i_waddr0 = 9; i_wdata0 = 32'h99;
        tick();
        i_clear = 1'b0; i_waddr0 = 5; i_wdata0 = 32'h4;
        count_busy(n);
        i_we0 = 1'b0;
        check("clear_busy_len", n, 32);
        i_raddr = {5'd5, 5'd9};
        #1 check("clear_r9", o_rdata[31:0], 32'h0);
        check("busy_write_r5", o_rdata[63:32], 32'h0);
        check_all_zero("clear_zero");

        // Reset mid-sweep
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        repeat (10) tick();
        check("mid_busy", 32'(o_busy), 32'h1);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        count_busy(n);
        check("restart_busy_len", n, 32);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            i_rst_n  = ($urandom_range(499) != 0);
            i_clear  = ($urandom_range(63) == 0);
            i_we0    = $urandom_range(1);
            i_we1    = $urandom_range(1);
            i_waddr0 = $urandom_range(1) ? 5'($urandom_range(3)) : 5'($urandom);
            i_waddr1 = $urandom_range(1) ? 5'($urandom_range(3)) : 5'($urandom);
            i_wdata0 = $urandom;
            i_wdata1 = $urandom;
            i_raddr[4:0] = $urandom_range(1) ? i_waddr0 : 5'($urandom);
            i_raddr[9:5] = $urandom_range(1) ? i_waddr1 : 5'($urandom_range(3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
